// File: rtl/power_seq_pkg.sv
// Shared types for the power sequencer: the 3-bit state encoding exposed on
// the state port.
package power_seq_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    PS_OFF       = 3'd0,
    PS_RAMP_UP   = 3'd1,
    PS_ON        = 3'd2,
    PS_RAMP_DOWN = 3'd3,
    PS_FAULT     = 3'd4
  } ps_state_e;

endpackage

// File: rtl/power_fault_filter.sv
// Fault debounce: OR of all fault sources must hold for FAULT_FILTER
// consecutive cycles before the filtered output asserts.
module power_fault_filter #(
  parameter int NUM_FAULTS   = 2,
  parameter int FAULT_FILTER = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_FAULTS-1:0] fault,
  output logic                  filtered
);

  localparam int FW = $clog2(FAULT_FILTER + 1);
  localparam logic [FW-1:0] FMAX = FW'(FAULT_FILTER);

  logic          raw;
  logic [FW-1:0] cnt;

  assign raw = |fault;

  // Saturates at FMAX so a long fault keeps filtered high without wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         cnt <= '0;
    else if (!raw)        cnt <= '0;
    else if (cnt != FMAX) cnt <= cnt + FW'(1);
  end

  assign filtered = (cnt == FMAX);

endmodule

// File: rtl/power_sequencer.sv
// Rail power sequencer: thermometer-coded rail enables stepped STEP_DELAY
// apart, debounced fault shutdown. Optional heartbeat watchdog in ON is
// compiled in with POWER_SEQ_WATCHDOG_EN.
module power_sequencer
  import power_seq_pkg::*;
#(
  parameter int NUM_RAILS    = 3,
  parameter int NUM_FAULTS   = 2,
  parameter int STEP_DELAY   = 1000,
  parameter int FAULT_FILTER = 4
`ifdef POWER_SEQ_WATCHDOG_EN
  ,parameter int WDT_CYCLES  = 50000
`endif
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable_req,
  input  logic [NUM_FAULTS-1:0] fault,
  input  logic                  fault_clear,
`ifdef POWER_SEQ_WATCHDOG_EN
  input  logic                  heartbeat,
`endif
  output logic [NUM_RAILS-1:0]  rail_en,
  output logic                  shutdown,
  output logic                  power_good,
  output logic [STATE_W-1:0]    state
);

  localparam int CW = $clog2(STEP_DELAY + 1);

  ps_state_e            st_q, st_nxt;
  logic [CW-1:0]        cnt_q, cnt_nxt;
  logic [NUM_RAILS-1:0] rail_nxt, rail_up, rail_dn;
  logic                 pg_nxt, sd_nxt;
  logic                 step_done;
  logic                 flt_filtered;
  logic                 fault_act;

  power_fault_filter #(
    .NUM_FAULTS  (NUM_FAULTS),
    .FAULT_FILTER(FAULT_FILTER)
  ) u_filter (
    .clk     (clk),
    .reset_n (reset_n),
    .fault   (fault),
    .filtered(flt_filtered)
  );

`ifdef POWER_SEQ_WATCHDOG_EN
  localparam int WW = $clog2(WDT_CYCLES + 1);
  logic          hb_q;
  logic [WW-1:0] wdt_cnt;
  logic          wdt_trip;

  // Counts ON cycles since the last heartbeat toggle; any other state idles it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hb_q    <= 1'b0;
      wdt_cnt <= '0;
    end else begin
      hb_q <= heartbeat;
      if (st_q != PS_ON || heartbeat != hb_q) wdt_cnt <= '0;
      else if (!wdt_trip)                    wdt_cnt <= wdt_cnt + WW'(1);
    end
  end

  assign wdt_trip  = (wdt_cnt == WW'(WDT_CYCLES));
  assign fault_act = flt_filtered | wdt_trip;
`else
  assign fault_act = flt_filtered;
`endif

  // Rails are thermometer coded, so one shift adds the lowest disabled rail
  // or removes the highest enabled one.
  assign rail_up   = (rail_en << 1) | NUM_RAILS'(1);
  assign rail_dn   = rail_en >> 1;
  assign step_done = (cnt_q == CW'(STEP_DELAY - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q       <= PS_OFF;
      cnt_q      <= '0;
      rail_en    <= '0;
      power_good <= 1'b0;
      shutdown   <= 1'b0;
    end else begin
      st_q       <= st_nxt;
      cnt_q      <= cnt_nxt;
      rail_en    <= rail_nxt;
      power_good <= pg_nxt;
      shutdown   <= sd_nxt;
    end
  end

  always_comb begin
    st_nxt   = st_q;
    rail_nxt = rail_en;
    cnt_nxt  = '0;
    if (fault_act) begin
      st_nxt   = PS_FAULT;
      rail_nxt = '0;
    end else begin
      case (st_q)
        PS_OFF: begin
          if (enable_req) begin
            st_nxt   = PS_RAMP_UP;
            rail_nxt = rail_up;
          end
        end
        PS_RAMP_UP: begin
          if (!enable_req) begin
            rail_nxt = rail_dn;
            st_nxt   = (rail_dn == '0) ? PS_OFF : PS_RAMP_DOWN;
          end else if (step_done) begin
            if (rail_en[NUM_RAILS-1]) st_nxt   = PS_ON;
            else                      rail_nxt = rail_up;
          end else begin
            cnt_nxt = cnt_q + CW'(1);
          end
        end
        PS_ON: begin
          if (!enable_req) begin
            rail_nxt = rail_dn;
            st_nxt   = (rail_dn == '0) ? PS_OFF : PS_RAMP_DOWN;
          end
        end
        PS_RAMP_DOWN: begin
          if (enable_req) begin
            rail_nxt = rail_up;
            st_nxt   = PS_RAMP_UP;
          end else if (step_done) begin
            rail_nxt = rail_dn;
            if (rail_dn == '0) st_nxt = PS_OFF;
          end else begin
            cnt_nxt = cnt_q + CW'(1);
          end
        end
        PS_FAULT: begin
          if (fault_clear) st_nxt = PS_OFF;
        end
        default: begin
          st_nxt   = PS_OFF;
          rail_nxt = '0;
        end
      endcase
    end
  end

  // Status flags follow the state being entered so they register with it.
  always_comb begin
    pg_nxt = (st_nxt == PS_ON);
    sd_nxt = (st_nxt == PS_FAULT);
  end

  assign state = st_q;

endmodule

// File: tb/tb_power_sequencer.sv
// Directed bench for power_sequencer: NUM_RAILS=3, STEP_DELAY=4, FAULT_FILTER=4.
module tb_power_sequencer;

  localparam logic [2:0] S_OFF = 3'd0, S_RU = 3'd1, S_ON = 3'd2,
                         S_RD  = 3'd3, S_FLT = 3'd4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable_req;
  logic [1:0] fault;
  logic       fault_clear;
  logic [2:0] rail_en;
  logic       shutdown;
  logic       power_good;
  logic [2:0] state;

  int ncheck = 0;
  int nfail  = 0;

  power_sequencer #(
    .NUM_RAILS   (3),
    .NUM_FAULTS  (2),
    .STEP_DELAY  (4),
    .FAULT_FILTER(4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable_req (enable_req),
    .fault      (fault),
    .fault_clear(fault_clear),
    .rail_en    (rail_en),
    .shutdown   (shutdown),
    .power_good (power_good),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [2:0] er, input logic ep,
                     input logic es, input logic [2:0] est);
    logic [7:0] obs, exp;
    obs = {state, shutdown, power_good, rail_en};
    exp = {est, es, ep, er};
    ncheck++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got state=%0d sd=%b pg=%b rail=%b, want state=%0d sd=%b pg=%b rail=%b",
             tag, state, shutdown, power_good, rail_en, est, es, ep, er);
    end
  endtask

  initial begin
    reset_n = 1'b0; enable_req = 1'b0; fault = 2'b00; fault_clear = 1'b0;
    #3 chk("reset", 3'b000, 0, 0, S_OFF);
    tick(2); reset_n = 1'b1;
    tick(2); chk("idle_off", 3'b000, 0, 0, S_OFF);

    // Power up
    enable_req = 1'b1;
    tick(1); chk("up_r0",      3'b001, 0, 0, S_RU);
    tick(3); chk("up_r0_hold", 3'b001, 0, 0, S_RU);
    tick(1); chk("up_r1",      3'b011, 0, 0, S_RU);
    tick(4); chk("up_r2",      3'b111, 0, 0, S_RU);
    tick(3); chk("up_pre_on",  3'b111, 0, 0, S_RU);
    tick(1); chk("on",         3'b111, 1, 0, S_ON);
    tick(5); chk("on_hold",    3'b111, 1, 0, S_ON);

    // Power down
    enable_req = 1'b0;
    tick(1); chk("dn_r2",      3'b011, 0, 0, S_RD);
    tick(4); chk("dn_r1",      3'b001, 0, 0, S_RD);
    tick(3); chk("dn_r0_hold", 3'b001, 0, 0, S_RD);
    tick(1); chk("dn_off",     3'b000, 0, 0, S_OFF);

    // Fault filter: 3-cycle glitch ignored, 4-cycle fault trips
    enable_req = 1'b1;
    tick(13); chk("on2", 3'b111, 1, 0, S_ON);
    fault = 2'b10; tick(3); fault = 2'b00; tick(3);
    chk("glitch3", 3'b111, 1, 0, S_ON);
    fault = 2'b10; tick(4); chk("flt_pre",  3'b111, 1, 0, S_ON);
    tick(1);                chk("flt_trip", 3'b000, 0, 1, S_FLT);

    // Clear blocked while fault persists; exit only once filtered fault drops
    fault_clear = 1'b1; tick(1); fault_clear = 1'b0;
    chk("clr_blocked", 3'b000, 0, 1, S_FLT);
    fault = 2'b00; tick(1); chk("flt_hold",   3'b000, 0, 1, S_FLT);
    tick(1);                chk("flt_no_clr", 3'b000, 0, 1, S_FLT);
    fault_clear = 1'b1; tick(1); fault_clear = 1'b0;
    chk("clr_off", 3'b000, 0, 0, S_OFF);
    tick(1); chk("restart", 3'b001, 0, 0, S_RU);

    // Reverse during ramp up at rail_en=011
    tick(4); chk("rev_at011", 3'b011, 0, 0, S_RU);
    enable_req = 1'b0;
    tick(1); chk("rev_dn",      3'b001, 0, 0, S_RD);
    tick(3); chk("rev_dn_hold", 3'b001, 0, 0, S_RD);
    tick(1); chk("rev_off",     3'b000, 0, 0, S_OFF);

    // Reverse during ramp down
    enable_req = 1'b1;
    tick(13); chk("on3", 3'b111, 1, 0, S_ON);
    enable_req = 1'b0;
    tick(1); chk("rd_enter", 3'b011, 0, 0, S_RD);
    tick(2); chk("rd_hold",  3'b011, 0, 0, S_RD);
    enable_req = 1'b1;
    tick(1); chk("ru_rev",     3'b111, 0, 0, S_RU);
    tick(3); chk("ru_rev_pre", 3'b111, 0, 0, S_RU);
    tick(1); chk("ru_rev_on",  3'b111, 1, 0, S_ON);

    // Asynchronous reset, including mid-RAMP_UP
    reset_n = 1'b0;
    #2 chk("rst_from_on", 3'b000, 0, 0, S_OFF);
    tick(1); reset_n = 1'b1;
    tick(1); chk("rst_up_r0", 3'b001, 0, 0, S_RU);
    tick(4); chk("rst_up_r1", 3'b011, 0, 0, S_RU);
    #3 reset_n = 1'b0;
    #1 chk("rst_async", 3'b000, 0, 0, S_OFF);
    tick(1); chk("rst_held", 3'b000, 0, 0, S_OFF);
    reset_n = 1'b1;
    tick(1); chk("rst_restart", 3'b001, 0, 0, S_RU);

    // Filter count restarts after a dropout; fault wins over held enable_req
    fault = 2'b01; tick(2); fault = 2'b00; tick(1);
    fault = 2'b01; tick(4); chk("flt_reset_pre", 3'b011, 0, 0, S_RU);
    tick(1); chk("flt_ramp", 3'b000, 0, 1, S_FLT);
    fault = 2'b00; enable_req = 1'b0; tick(1);
    fault_clear = 1'b1; tick(1); fault_clear = 1'b0;
    chk("final_off", 3'b000, 0, 0, S_OFF);

    $display("End of test - %0d assertions evaluated, %0d failures", ncheck, nfail);
    $finish;
  end

endmodule

// File: doc/power_sequencer.md
POWER_SEQUENCER -- requirements
Module: power_sequencer

Interface
REQ-001 SHALL have parameter NUM_RAILS, default 3: number of sequenced rail enables.
REQ-002 SHALL have parameter NUM_FAULTS, default 2: number of fault inputs.
REQ-003 SHALL have parameter STEP_DELAY, default 1000: cycles between successive rail transitions (>=1).
REQ-004 SHALL have parameter FAULT_FILTER, default 4: consecutive cycles a fault must persist to count (>=1).
REQ-005 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port enable_req  in  1  level; 1 = power up, 0 = power down.
REQ-008 SHALL have port fault  in  NUM_FAULTS  level fault sources, any bit high = fault.
REQ-009 SHALL have port fault_clear  in  1  single-cycle pulse to leave FAULT.
REQ-010 SHALL have port rail_en  out  NUM_RAILS  registered rail enables, bit 0 first on.
REQ-011 SHALL have port shutdown  out  1  registered; 1 while in FAULT, drives downstream GPIO shutdown.
REQ-012 SHALL have port power_good  out  1  registered; 1 only in ON.
REQ-013 SHALL have port state  out  3  current state encoding.

Function
REQ-014 SHALL implement states OFF, RAMP_UP, ON, RAMP_DOWN, FAULT.
REQ-015 OFF with enable_req=1 sampled at edge t SHALL set rail_en[0]=1 at t+1 and enter RAMP_UP.
REQ-016 RAMP_UP SHALL set rail_en[k] exactly STEP_DELAY cycles after rail_en[k-1], k ascending.
REQ-017 SHALL enter ON and set power_good=1 STEP_DELAY cycles after the last rail enables.
REQ-018 ON with enable_req=0 SHALL clear power_good next cycle, enter RAMP_DOWN and clear rail_en[NUM_RAILS-1] that same cycle.
REQ-019 RAMP_DOWN SHALL clear rails in descending order, STEP_DELAY cycles apart, then enter OFF once rail_en[0] clears.
REQ-020 enable_req=0 during RAMP_UP SHALL reverse to RAMP_DOWN from the highest enabled rail, keeping the step counter phase reset to 0.
REQ-021 enable_req=1 during RAMP_DOWN SHALL reverse to RAMP_UP from the lowest disabled rail, step counter reset to 0.
REQ-022 Filtered fault (any fault bit high FAULT_FILTER consecutive sampled cycles) SHALL, on the next cycle, force rail_en=0, shutdown=1, power_good=0 and enter FAULT from any state.
REQ-023 Fault SHALL take priority over enable_req and fault_clear on the same cycle.
REQ-024 FAULT SHALL exit to OFF only on fault_clear=1 while the filtered fault is 0; otherwise remain.
REQ-025 After FAULT exit, power-up SHALL require enable_req sampled 1 in OFF (a held-high enable_req restarts the sequence).
REQ-026 Step counter SHALL be $clog2(STEP_DELAY+1) bits and saturate/reload without wrap.
REQ-027 Any fault bit dropping before FAULT_FILTER cycles SHALL reset the filter count to 0.

Reset
REQ-028 reset_n=0 SHALL asynchronously force state=OFF, rail_en=0, shutdown=0, power_good=0, counters and filter count=0.
REQ-029 Reset mid-sequence SHALL drop all rails at once; release SHALL await enable_req in OFF.

Configuration
REQ-030 With macro POWER_SEQ_WATCHDOG_EN defined, SHALL add input heartbeat (1 bit) and parameter WDT_CYCLES (default 50000); in ON, no heartbeat edge for WDT_CYCLES cycles SHALL be treated as a filtered fault.
REQ-031 Without POWER_SEQ_WATCHDOG_EN, SHALL have no heartbeat port and no watchdog logic.

Structure
REQ-032 Package power_seq_pkg SHALL hold the state enumeration (3-bit) and state encodings used by state.
REQ-033 Fault debounce SHALL be sub-module power_fault_filter (OR-reduce, consecutive counter, filtered output).

Verification
REQ-034 NUM_RAILS=3, STEP_DELAY=4: enable_req rises edge 0 -> rail_en=001@1, 011@5, 111@9, power_good@13.
REQ-035 From ON, enable_req falls edge 0 -> power_good=0 and rail_en=011@1, 001@5, 000@9, state OFF@9.
REQ-036 FAULT_FILTER=4: fault[1] high 3 cycles then low -> no change; high 4 cycles during ON -> rail_en=0, shutdown=1 next cycle.
REQ-037 In FAULT, fault_clear while fault high -> stays FAULT; fault low then fault_clear -> OFF next cycle, shutdown=0.
REQ-038 enable_req falls at rail_en=011 during RAMP_UP -> rail_en=001 next cycle, 000 after 4 more, OFF.
REQ-039 reset_n asserted mid-RAMP_UP -> all outputs 0 immediately, no clock edge required.
